// File: rtl/pipe_register.sv
// Multi-stage valid/ready pipeline register with bubble collapse, flush and
// occupancy count. Every stage is a full register; only in_ready is combinational.
package soc_pkg;
  localparam int DATA_WIDTH = 32;
endpackage

module pipe_register #(
  parameter int                    DATA_WIDTH = soc_pkg::DATA_WIDTH,
  parameter int                    DEPTH      = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        d,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [DATA_WIDTH-1:0]        out,
  output logic                         out_valid,
  input  logic                         out_ready,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH+1);

  // Handshake: a word moves across a boundary on a rising edge when the sender's
  // valid and the receiver's ready are both high in the preceding cycle; valid
  // never depends on ready, and ready may depend on valid only downstream.
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_d [DEPTH];
  logic [CW-1:0]         count_q, count_d;
  logic [DEPTH-1:0]      ready;

  // A stage can load if it is empty or anything downstream will make room.
  always_comb begin
    logic r;
    r = out_ready;
    ready = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      r = r | ~valid_q[k];
      ready[k] = r;
    end
  end

  always_comb begin
    logic                  up_v;
    logic [DATA_WIDTH-1:0] up_d;
    valid_d = valid_q;
    data_d  = data_q;
    count_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (k == 0) begin
        up_v = in_valid;
        up_d = d;
      end else begin
        up_v = valid_q[k-1];
        up_d = data_q[k-1];
      end
      if (ready[k]) begin
        valid_d[k] = up_v;
        if (up_v) data_d[k] = up_d;
      end
    end
    // Flush wins over every transfer and deliberately leaves the data untouched.
    if (flush) begin
      valid_d = '0;
      data_d  = data_q;
    end
    for (int k = 0; k < DEPTH; k++) begin
      count_d = count_d + CW'(valid_d[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      count_q <= '0;
      for (int k = 0; k < DEPTH; k++) data_q[k] <= RESET_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign in_ready  = ready[0] & ~flush;
  assign out       = data_q[DEPTH-1];
  assign out_valid = valid_q[DEPTH-1];
  assign count     = count_q;

endmodule

// File: doc/pipe_register.md
PIPE_REGISTER -- requirements
Module: pipe_register

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default soc_pkg DATA_WIDTH, meaning the payload width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 2, legal range 1..16, meaning the number of register stages.
REQ-003 The block SHALL have parameter RESET_VAL, default 0 of width DATA_WIDTH, meaning the data value loaded on reset.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port d, input, DATA_WIDTH bits: upstream data.
REQ-007 The block SHALL have port in_valid, input, 1 bit: upstream data valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block accepts d this cycle.
REQ-009 The block SHALL have port out, output, DATA_WIDTH bits: downstream data.
REQ-010 The block SHALL have port out_valid, output, 1 bit: out holds a valid word.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream accepts out this cycle.
REQ-012 The block SHALL have port flush, input, 1 bit: synchronous discard of all held words.
REQ-013 The block SHALL have port count, output, $clog2(DEPTH+1) bits: number of valid stages.

Function
REQ-014 Stages k=0..DEPTH-1 SHALL each hold valid_k and data_k; stage 0 is fed from d, and stage DEPTH-1 drives out/out_valid.
REQ-015 Each stage SHALL have ready_k = !valid_k || ready_(k+1), with ready_DEPTH = out_ready; in_ready = ready_0 && !flush.
REQ-016 An input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready.
REQ-017 At each edge with ready_k high, valid_k SHALL load the upstream valid, and data_k SHALL load the upstream data only if the upstream valid is 1; otherwise the stage SHALL hold.
REQ-018 Latency, with no stall, SHALL be exactly DEPTH rising edges from input transfer to the word on out.
REQ-019 Throughput SHALL be one word per cycle sustained with out_ready=1.
REQ-020 Bubbles SHALL collapse: a word advances into an empty downstream stage even when out_ready=0.
REQ-021 Word order SHALL be preserved, with no loss and no duplication.
REQ-022 While out_valid=1 and out_ready=0, out SHALL remain stable until the transfer.
REQ-023 When in_valid=0, d SHALL be ignored.
REQ-024 Simultaneous input and output transfers on a full pipe SHALL both complete on the same edge, and count SHALL be unchanged.
REQ-025 flush=1 SHALL clear all valid_k at the next edge, SHALL take priority over all transfers, SHALL force in_ready=0 that cycle, and SHALL leave data_k unchanged.
REQ-026 count SHALL equal the number of set valid_k bits, updated on the same edge as those bits.
REQ-027 With DEPTH=1, the block SHALL behave as a single stage with in_ready = !valid_0 || out_ready.
REQ-028 The only combinational path SHALL be out_ready/flush -> in_ready; out, out_valid and count SHALL be registered.

Reset
REQ-029 While rst=1, regardless of clk: all valid_k SHALL be 0, all data_k SHALL be RESET_VAL, out_valid SHALL be 0, out SHALL be RESET_VAL, and count SHALL be 0.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight words; no transfer occurs on an edge while rst=1.
REQ-031 After rst deasserts, the first input transfer SHALL be possible at the next rising edge.

Verification (DATA_WIDTH=8, DEPTH=3)
REQ-032 Reset: pipe holding 0x11,0x22; raise rst between edges -> out_valid=0, out=0x00 and count=0 immediately, without a clock edge.
REQ-033 Streaming: out_ready=1, push 0x11,0x22,0x33 on consecutive edges -> out=0x11 valid 3 edges after its accept, then 0x22 and 0x33 on the following cycles.
REQ-034 Backpressure: out_ready=0, offer 0xA1..0xA4 -> 3 accepted, in_ready=0, count=3, out=0xA1 stable; then out_ready=1 -> A1,A2,A3,A4 emitted in order with none lost or duplicated.
REQ-035 Bubble collapse: empty pipe, out_ready=0, push 0x5A once -> after 3 edges out_valid=1, out=0x5A, count=1 and in_ready=1.
REQ-036 Flush: full pipe, in_valid=1, d=0xFF, flush=1 for one cycle -> in_ready=0 that cycle; next edge count=0, out_valid=0 and 0xFF is not accepted.
REQ-037 Simultaneous: full pipe, out_ready=1, in_valid=1, d=0x77 -> one word out and 0x77 in on the same edge, count stays 3, and 0x77 emerges 3 edges later.
